// File: rtl/parking_pkg.sv
// Shared definitions for the parking access controller: register map,
// EVENT register bit positions, reset defaults and the event decoder.
package parking_pkg;

   localparam int unsigned ADDR_EVENT  = 0;
   localparam int unsigned ADDR_CAP    = 1;
   localparam int unsigned ADDR_OCC    = 2;
   localparam int unsigned ADDR_DELAY  = 3;
   localparam int unsigned ADDR_STATUS = 4;

   localparam int EVT_ENTRY_BIT = 0;
   localparam int EVT_EXIT_BIT  = 1;

   localparam int DEF_CAP_C   = 16;
   localparam int DEF_DELAY_C = 5;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'b00,
      EVT_ENTRY = 2'b01,
      EVT_EXIT  = 2'b10,
      EVT_BOTH  = 2'b11
   } evt_kind_e;

   function automatic evt_kind_e decode_evt(input logic entry_b, input logic exit_b);
      return evt_kind_e'({exit_b, entry_b});
   endfunction

endpackage

// File: rtl/parking_barrier_timer.sv
// Barrier hold timer: a down-counter loaded on every opening request.
// The barrier is open while the counter has not reached terminal count.
// Ports:
//   clk, rst_n   clock, synchronous active-high reset
//   load         open (or re-open) request, reloads the counter
//   delay        hold duration in cycles; 0 is treated as 1
//   bariera      barrier open
module parking_barrier_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] delay,
   output logic         bariera
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (delay == '0) ? W'(1) : delay;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Loaded at the opening edge, so the output is high from the next
   // cycle for exactly the loaded number of cycles.
   assign bariera = (cnt_q != '0);

endmodule

// File: rtl/parking_access_ctrl.sv
// Parking-lot access controller behind a zero-wait-state APB slave.
// Software posts entry/exit events; occupancy is tracked against a
// programmable capacity, the barrier is pulsed open for a programmable
// time, and the free-spot display and full flag are driven registered.
// Ports:
//   clk, rst_n                  clock, synchronous active-high reset
//   Paddr/Pwrite/Psel/Penable/Pwdata   APB request
//   Prdata/Pready/Pslverr       APB response
//   bariera                     barrier open
//   afisare_locuri              free spots, saturating at 0
//   parcare_full                occupancy >= capacity
module parking_access_ctrl
   import parking_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int DEF_CAP   = DEF_CAP_C,
   parameter int DEF_DELAY = DEF_DELAY_C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] Paddr,
   input  logic              Pwrite,
   input  logic              Psel,
   input  logic              Penable,
   input  logic [DATA_W-1:0] Pwdata,
   output logic [DATA_W-1:0] Prdata,
   output logic              Pready,
   output logic              Pslverr,
   output logic              bariera,
   output logic [DATA_W-1:0] afisare_locuri,
   output logic              parcare_full
);

   logic [DATA_W-1:0] cap_q,   cap_d;
   logic [DATA_W-1:0] occ_q,   occ_d;
   logic [DATA_W-1:0] delay_q, delay_d;
   logic [DATA_W-1:0] disp_q,  disp_d;
   logic              full_q,  full_d;

   logic              access;
   logic              hit_event, hit_cap, hit_occ, hit_delay, hit_status;
   logic              mapped, xfer_err, wr_ok;
   logic              open_req;
   logic [DATA_W-1:0] rdata;
   evt_kind_e         evt;

   assign access     = Psel & Penable;
   assign hit_event  = (Paddr == ADDR_W'(ADDR_EVENT));
   assign hit_cap    = (Paddr == ADDR_W'(ADDR_CAP));
   assign hit_occ    = (Paddr == ADDR_W'(ADDR_OCC));
   assign hit_delay  = (Paddr == ADDR_W'(ADDR_DELAY));
   assign hit_status = (Paddr == ADDR_W'(ADDR_STATUS));
   assign mapped     = hit_event | hit_cap | hit_occ | hit_delay | hit_status;
   assign xfer_err   = access & (~mapped | (Pwrite & (hit_occ | hit_status)));
   assign wr_ok      = access & Pwrite & ~xfer_err;

   always_comb begin
      rdata = '0;
      if (hit_cap)    rdata = cap_q;
      if (hit_occ)    rdata = occ_q;
      if (hit_delay)  rdata = delay_q;
      if (hit_status) rdata = {{(DATA_W-2){1'b0}}, full_q, bariera};
   end

   // rst_n is active high; a transfer that overlaps reset returns nothing.
   assign Pready  = access;
   assign Pslverr = xfer_err & ~rst_n;
   assign Prdata  = (access & ~Pwrite & ~rst_n) ? rdata : '0;

   always_comb begin
      cap_d    = cap_q;
      occ_d    = occ_q;
      delay_d  = delay_q;
      open_req = 1'b0;
      evt      = decode_evt(Pwdata[EVT_ENTRY_BIT], Pwdata[EVT_EXIT_BIT]);

      // Both bits on an empty lot collapse to a plain entry.
      if ((evt == EVT_BOTH) && (occ_q == '0)) begin
         evt = EVT_ENTRY;
      end

      if (wr_ok && hit_cap)   cap_d   = Pwdata;
      if (wr_ok && hit_delay) delay_d = Pwdata;

      if (wr_ok && hit_event) begin
         unique case (evt)
            EVT_ENTRY: begin
               if ((occ_q < cap_q) && (occ_q != '1)) begin
                  occ_d    = occ_q + DATA_W'(1);
                  open_req = 1'b1;
               end
            end
            EVT_EXIT: begin
               if (occ_q != '0) begin
                  occ_d    = occ_q - DATA_W'(1);
                  open_req = 1'b1;
               end
            end
            EVT_BOTH: open_req = 1'b1;
            default:  ;
         endcase
      end

      disp_d = (cap_q > occ_q) ? (cap_q - occ_q) : '0;
      full_d = (occ_q >= cap_q);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cap_q   <= DATA_W'(DEF_CAP);
         occ_q   <= '0;
         delay_q <= DATA_W'(DEF_DELAY);
         disp_q  <= DATA_W'(DEF_CAP);
         full_q  <= 1'b0;
      end else begin
         cap_q   <= cap_d;
         occ_q   <= occ_d;
         delay_q <= delay_d;
         disp_q  <= disp_d;
         full_q  <= full_d;
      end
   end

   assign afisare_locuri = disp_q;
   assign parcare_full   = full_q;

   parking_barrier_timer #(
      .W (DATA_W)
   ) u_barrier_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (open_req),
      .delay   (delay_q),
      .bariera (bariera)
   );

endmodule

// File: tb/tb_parking_access_ctrl.sv
module tb_parking_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] paddr, pwdata;
   logic       pwrite, psel, penable;
   logic [7:0] prdata, afisare;
   logic       pready, pslverr, bariera, full;

   always #5 clk = ~clk;

   parking_access_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Paddr          (paddr),
      .Pwrite         (pwrite),
      .Psel           (psel),
      .Penable        (penable),
      .Pwdata         (pwdata),
      .Prdata         (prdata),
      .Pready         (pready),
      .Pslverr        (pslverr),
      .bariera        (bariera),
      .afisare_locuri (afisare),
      .parcare_full   (full)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 0;

   // Reference state: lot registers plus cycles of barrier-open time left.
   int m_cap = 16, m_occ = 0, m_delay = 5, m_bar = 0, m_disp = 16;
   bit m_full = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int pocc, pcap;
      bit en, ex, open;
      pocc = m_occ;
      pcap = m_cap;
      open = 0;
      if (rst_n) begin
         m_cap = 16; m_occ = 0; m_delay = 5; m_bar = 0; m_disp = 16; m_full = 0;
      end else begin
         m_disp = (pcap > pocc) ? pcap - pocc : 0;
         m_full = (pocc >= pcap);
         if (m_bar > 0) m_bar--;
         if (psel && penable && pwrite) begin
            case (paddr)
               8'd0: begin
                  en = pwdata[0];
                  ex = pwdata[1];
                  if (en && ex && pocc == 0) ex = 0;
                  if (en && !ex) begin
                     if (pocc < pcap) begin m_occ = pocc + 1; open = 1; end
                  end else if (!en && ex) begin
                     if (pocc > 0) begin m_occ = pocc - 1; open = 1; end
                  end else if (en && ex) begin
                     open = 1;
                  end
                  if (open) m_bar = (m_delay == 0) ? 1 : m_delay;
               end
               8'd1: m_cap = pwdata;
               8'd3: m_delay = pwdata;
               default: ;
            endcase
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      bit acc, exp_err;
      int exp_rd;
      @(negedge clk);
      if (cmp_en) begin
         acc     = psel && penable;
         exp_err = acc && !rst_n && (paddr > 8'd4 || (pwrite && (paddr == 8'd2 || paddr == 8'd4)));
         exp_rd  = 0;
         if (acc && !pwrite && !rst_n) begin
            case (paddr)
               8'd1: exp_rd = m_cap;
               8'd2: exp_rd = m_occ;
               8'd3: exp_rd = m_delay;
               8'd4: exp_rd = (m_full ? 2 : 0) + ((m_bar > 0) ? 1 : 0);
               default: exp_rd = 0;
            endcase
         end
         chk("bariera", bariera, (m_bar > 0));
         chk("afisare", afisare, m_disp);
         chk("full", full, m_full);
         chk("pready", pready, acc);
         chk("pslverr", pslverr, exp_err);
         chk("prdata", prdata, exp_rd);
      end
   end

   // Called at 1 time unit after a rising edge; returns at the same phase.
   task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d, input bit abort,
                       output logic [7:0] rd, output logic err);
      psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1;
      if (abort) rst_n = 1;
      @(negedge clk);
      rd  = prdata;
      err = pslverr;
      @(posedge clk); #1;
      psel = 0; penable = 0; pwrite = 0;
      rst_n = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      logic [7:0] r; logic e;
      xfer(1, a, d, 0, r, e);
   endtask

   task automatic wr_err(input string name, input logic [7:0] a, input logic [7:0] d, input logic exp_e);
      logic [7:0] r; logic e;
      xfer(1, a, d, 0, r, e);
      chk(name, e, exp_e);
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp_d, input logic exp_e);
      logic [7:0] r; logic e;
      xfer(0, a, 8'h00, 0, r, e);
      chk({name, "_data"}, r, exp_d);
      chk({name, "_err"}, e, exp_e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1;
      @(posedge clk); #1;
      rst_n = 0;
   endtask

   task automatic count_open(input string name, input int exp_n);
      int n = 0;
      bit closed = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bariera) n++;
         else begin closed = 1; break; end
      end
      chk({name, "_closed"}, closed, 1);
      chk({name, "_cycles"}, n, exp_n);
      @(posedge clk); #1;
   endtask

   task automatic wait_closed();
      bit closed = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!bariera) begin closed = 1; break; end
      end
      chk("wait_barrier_closed", closed, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r; logic e;
      logic [7:0] exp_full_t [5];
      logic [7:0] exp_disp_t [5];
      exp_full_t = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
      exp_disp_t = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};

      rst_n = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      @(posedge clk); #1;
      cmp_en = 1;
      rst_n = 0;

      // defaults
      rd_chk("rst_cap", 8'd1, 8'd16, 0);
      rd_chk("rst_occ", 8'd2, 8'd0, 0);
      rd_chk("rst_delay", 8'd3, 8'd5, 0);
      rd_chk("rst_status", 8'd4, 8'd0, 0);
      chk("rst_afisare", afisare, 16);
      chk("rst_full", full, 0);

      // single entry, then back-to-back reload, then DELAY=0
      wr(8'd0, 8'd1);
      count_open("entry", 5);
      rd_chk("entry_occ", 8'd2, 8'd1, 0);
      chk("entry_afisare", afisare, 15);
      wr(8'd0, 8'd1);
      wr(8'd0, 8'd1);
      count_open("reload", 5);
      rd_chk("reload_occ", 8'd2, 8'd3, 0);
      wr(8'd3, 8'd0);
      wr(8'd0, 8'd1);
      count_open("delay0", 1);
      wr(8'd3, 8'd2);
      wr(8'd0, 8'd2);
      count_open("delay2_exit", 2);
      rd_chk("exit_occ", 8'd2, 8'd3, 0);

      // full lot
      do_reset();
      wr(8'd1, 8'd3);
      repeat (3) wr(8'd0, 8'd1);
      wait_closed();
      wr(8'd0, 8'd1);
      chk("reject_bariera", bariera, 0);
      rd_chk("full_occ", 8'd2, 8'd3, 0);
      chk("full_flag", full, 1);
      chk("full_afisare", afisare, 0);
      rd_chk("full_status", 8'd4, 8'd2, 0);

      // capacity lowered below occupancy, then raised step by step
      do_reset();
      repeat (5) wr(8'd0, 8'd1);
      wr(8'd1, 8'd2);
      idle(1);
      chk("capdn_full", full, 1);
      chk("capdn_afisare", afisare, 0);
      rd_chk("capdn_occ", 8'd2, 8'd5, 0);
      for (int c = 3; c <= 7; c++) begin
         wr(8'd1, 8'(c));
         idle(1);
         chk("capup_full", full, exp_full_t[c-3]);
         chk("capup_afisare", afisare, exp_disp_t[c-3]);
      end
      wr(8'd0, 8'd1);
      rd_chk("capup_entry_occ", 8'd2, 8'd6, 0);

      // simultaneous bits
      do_reset();
      wr(8'd1, 8'd2);
      repeat (2) wr(8'd0, 8'd1);
      wait_closed();
      wr(8'd0, 8'd3);
      chk("both_full_bariera", bariera, 1);
      rd_chk("both_full_occ", 8'd2, 8'd2, 0);
      do_reset();
      wr(8'd0, 8'd2);
      chk("exit_empty_bariera", bariera, 0);
      rd_chk("exit_empty_occ", 8'd2, 8'd0, 0);
      wr(8'd0, 8'd3);
      rd_chk("both_empty_occ", 8'd2, 8'd1, 0);

      // errors
      rd_chk("unmapped_rd", 8'd7, 8'd0, 1);
      wr_err("wr_occ_err", 8'd2, 8'd9, 1);
      rd_chk("wr_occ_nochange", 8'd2, 8'd1, 0);
      wr_err("wr_status_err", 8'd4, 8'd3, 1);
      rd_chk("event_rd", 8'd0, 8'd0, 0);
      wr_err("wr_unmapped_err", 8'd5, 8'd1, 1);
      rd_chk("cap_after_errs", 8'd1, 8'd16, 0);

      // reset in the middle of activity
      wr(8'd1, 8'd9);
      wr(8'd3, 8'd2);
      wr(8'd0, 8'd1);
      do_reset();
      rd_chk("rst2_cap", 8'd1, 8'd16, 0);
      rd_chk("rst2_occ", 8'd2, 8'd0, 0);
      rd_chk("rst2_delay", 8'd3, 8'd5, 0);
      rd_chk("rst2_status", 8'd4, 8'd0, 0);

      // randomized traffic checked every cycle against the model
      for (int it = 0; it < 1500; it++) begin
         int sel;
         bit ab;
         logic [7:0] d;
         sel = $urandom_range(0, 99);
         ab  = ($urandom_range(0, 79) == 0);
         if (sel < 40) begin
            d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            xfer(1, 8'd0, d, ab, r, e);
         end else if (sel < 50) begin
            d = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 10));
            xfer(1, 8'd1, d, ab, r, e);
         end else if (sel < 55) begin
            xfer(1, 8'd3, 8'($urandom_range(0, 6)), ab, r, e);
         end else if (sel < 85) begin
            xfer(0, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), ab, r, e);
         end else if (sel < 95) begin
            xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ab, r, e);
         end else begin
            idle($urandom_range(1, 4));
         end
      end

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
